tag_alloc_sched: RTL and testbench
==================================

Name: tag_alloc_sched

Overview:
64-entry tag allocator and scheduler built around a 64-bit lowest-set-bit finder. It holds a free bitmap and grants at most one tag per cycle to the allocating stage. It accepts up to two tag releases per cycle from retire/writeback. It keeps a reserve watermark so that low-priority requesters cannot drain the pool.

Parameters:
RESV, 4, entries held back from non-priority requests; legal range 0..63
NENT, 64, entry count; fixed at 64 because the finder is 64 bits wide

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
alloc_req  in  1  request one tag this cycle
alloc_prio  in  1  priority request; may dip into the reserve
alloc_gnt  out  1  registered; tag granted in the previous cycle
alloc_tag  out  6  registered; granted tag, valid when alloc_gnt=1
free0_en  in  1  release port 0 valid
free0_tag  in  6  tag released on port 0
free1_en  in  1  release port 1 valid
free1_tag  in  6  tag released on port 1
flush  in  1  return every tag to the free pool
free_cnt  out  7  registered count of free tags, 0..64
empty  out  1  free_cnt==0; combinational from the register
busy_map  out  64  inverse of the free bitmap; registered
err_dblfree  out  1  registered one-cycle pulse on an illegal release

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- State: free map fm[63:0] (1 = free), cnt[6:0], and output registers.
- Reset values: fm=all ones, cnt=64, alloc_gnt=0, alloc_tag=0, err_dblfree=0, busy_map=0, empty=0.
- Grant condition in cycle N: alloc_req & ~flush & (fm!=0) & (alloc_prio | cnt>RESV).
- Pick rule: the lowest-index set bit of the registered fm. Frees presented in cycle N are never visible to the cycle-N pick.
- Latency: when the grant condition holds in cycle N, alloc_gnt=1 and alloc_tag=pick appear in cycle N+1, and fm[pick] clears at the same edge.
- When the grant condition fails, alloc_gnt=0 in cycle N+1 and alloc_tag holds its previous value.
- No backpressure on the grant. The requester must accept the tag in the cycle alloc_gnt=1.
- Release: freeX_en with fm[freeX_tag]==0 sets the bit at the edge.
- A release of an already-free tag is a double free: that bit is unchanged and err_dblfree=1 next cycle.
- free0 and free1 naming the same tag in one cycle: the tag is freed once and err_dblfree pulses.
- A release of the tag picked in the same cycle cannot be legal, because the picked tag is free. It is treated as a double free and the grant still proceeds.
- Counter: cnt_next = cnt - grant + number of legal distinct releases. No wrap is possible under legal use.
- Assertion (simulation only): cnt equals popcount(fm) every cycle.
- Flush overrides all other inputs: fm=all ones, cnt=64, alloc_gnt=0, err_dblfree=0 next cycle. Releases in the flush cycle are ignored and are not flagged.
- rst asserted mid-operation behaves exactly like the reset values above. It takes priority over flush.
- busy_map=~fm is registered alongside fm. empty=(cnt==0).

Decomposition:
- Shared package: TAG_W=6, NENT=64, and a typedef tag_t of 6 bits.
- Sub-module: alloc_pick64. It is a combinational lowest-set-bit finder: 64-bit in, 6-bit index out, plus a hasany flag. It is instantiated once on fm.
- Everything else lives in tag_alloc_sched: fm/cnt update, grant logic, release legality checks.

Test Plan:
- Reset, then alloc_req=1,alloc_prio=1 for 3 cycles -> grants with tags 0,1,2 on consecutive cycles starting 1 cycle later; free_cnt 64→63→62→61.
- Allocate tags 0..5, free5_tag via free0_tag=3 while alloc_req=1 that cycle -> that cycle's grant is tag 6 (not 3); the next grant is tag 3; free_cnt is unchanged across the overlap cycle.
- RESV=4, alloc_prio=0 continuous from reset -> exactly 60 grants, then alloc_gnt=0 with free_cnt=4; raise alloc_prio -> 4 more grants (tags 60..63), then empty=1 and alloc_gnt stays 0.
- Allocate tag 0; free0_tag=0 and free1_tag=0 in the same cycle -> free_cnt increments by 1 only and err_dblfree pulses once.
- Free the already-free tag 9 -> err_dblfree=1 for one cycle, fm unchanged.
- With 10 tags held, assert flush together with alloc_req and free0_en -> alloc_gnt=0, free_cnt=64, busy_map=0, no error; the next request grants tag 0.

Source files
------------

// File: rtl/tag_alloc_sched_pkg.sv
// Shared constants and types for the tag allocator/scheduler.
package tag_alloc_sched_pkg;
    localparam int TAG_W = 6;
    localparam int NENT  = 64;
    typedef logic [TAG_W-1:0] tag_t;
endpackage

// File: rtl/tag_alloc_sched_alloc_pick64.sv
// Combinational lowest-set-bit finder over a 64-bit vector.
module alloc_pick64
    import tag_alloc_sched_pkg::*;
(
    input  logic [NENT-1:0] i_vec,
    output tag_t            o_idx,
    output logic            o_hasany
);

    // Scan from the top down so the lowest set bit is the last write and wins.
    always_comb begin
        o_idx    = '0;
        o_hasany = |i_vec;
        for (int i = NENT - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = tag_t'(i);
            end
        end
    end

endmodule

// File: rtl/tag_alloc_sched.sv
// 64-entry tag allocator: one grant per cycle, two releases per cycle, reserve watermark.
module tag_alloc_sched
    import tag_alloc_sched_pkg::*;
#(
    parameter int unsigned RESV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_req,
    input  logic            alloc_prio,
    output logic            alloc_gnt,
    output tag_t            alloc_tag,
    input  logic            free0_en,
    input  tag_t            free0_tag,
    input  logic            free1_en,
    input  tag_t            free1_tag,
    input  logic            flush,
    output logic [6:0]      free_cnt,
    output logic            empty,
    output logic [NENT-1:0] busy_map,
    output logic            err_dblfree
);

    logic [NENT-1:0] r_fm;
    logic [6:0]      r_cnt;
    logic            r_gnt;
    tag_t            r_tag;
    logic            r_err;
    logic [NENT-1:0] r_busy;

    tag_t            w_pick;
    logic            w_hasany;
    logic            w_grant;
    logic            w_f0_ok;
    logic            w_f1_ok;
    logic            w_err;
    logic [NENT-1:0] w_clr;
    logic [NENT-1:0] w_set;
    logic [NENT-1:0] w_fm_nxt;
    logic [6:0]      w_cnt_nxt;

    alloc_pick64 u_pick (
        .i_vec    (r_fm),
        .o_idx    (w_pick),
        .o_hasany (w_hasany)
    );

    assign w_grant = alloc_req & ~flush & w_hasany & (alloc_prio | (r_cnt > 7'(RESV)));

    // A release is legal only if the tag is currently busy. The picked tag is
    // free by construction, so releasing it is caught here as a double free.
    // Port 1 naming the same tag as port 0 is treated as the duplicate.
    assign w_f0_ok = free0_en & ~r_fm[free0_tag];
    assign w_f1_ok = free1_en & ~r_fm[free1_tag] & ~(free0_en & (free1_tag == free0_tag));
    assign w_err   = (free0_en & ~w_f0_ok) | (free1_en & ~w_f1_ok);

    assign w_clr     = {{(NENT-1){1'b0}}, w_grant} << w_pick;
    assign w_set     = ({{(NENT-1){1'b0}}, w_f0_ok} << free0_tag)
                     | ({{(NENT-1){1'b0}}, w_f1_ok} << free1_tag);
    assign w_fm_nxt  = (r_fm & ~w_clr) | w_set;
    assign w_cnt_nxt = r_cnt - {6'd0, w_grant} + {6'd0, w_f0_ok} + {6'd0, w_f1_ok};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fm   <= '1;
            r_busy <= '0;
            r_cnt  <= 7'(NENT);
            r_gnt  <= 1'b0;
            r_tag  <= '0;
            r_err  <= 1'b0;
        end else if (flush) begin
            r_fm   <= '1;
            r_busy <= '0;
            r_cnt  <= 7'(NENT);
            r_gnt  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_fm   <= w_fm_nxt;
            r_busy <= ~w_fm_nxt;
            r_cnt  <= w_cnt_nxt;
            r_gnt  <= w_grant;
            r_err  <= w_err;
            if (w_grant) begin
                r_tag <= w_pick;
            end
        end
    end

    assign alloc_gnt   = r_gnt;
    assign alloc_tag   = r_tag;
    assign free_cnt    = r_cnt;
    assign empty       = (r_cnt == 7'd0);
    assign busy_map    = r_busy;
    assign err_dblfree = r_err;

    a_cnt_matches_map: assert property (@(posedge clk) disable iff (rst)
        (r_cnt == 7'($countones(r_fm))));

endmodule

// File: tb/tb_tag_alloc_sched.sv
// Directed bench for tag_alloc_sched with hand-computed expectations.
module tb_tag_alloc_sched;
    import tag_alloc_sched_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            alloc_req;
    logic            alloc_prio;
    logic            alloc_gnt;
    tag_t            alloc_tag;
    logic            free0_en;
    tag_t            free0_tag;
    logic            free1_en;
    tag_t            free1_tag;
    logic            flush;
    logic [6:0]      free_cnt;
    logic            empty;
    logic [NENT-1:0] busy_map;
    logic            err_dblfree;

    int n_chk  = 0;
    int n_pass = 0;

    tag_alloc_sched #(.RESV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_req   (alloc_req),
        .alloc_prio  (alloc_prio),
        .alloc_gnt   (alloc_gnt),
        .alloc_tag   (alloc_tag),
        .free0_en    (free0_en),
        .free0_tag   (free0_tag),
        .free1_en    (free1_en),
        .free1_tag   (free1_tag),
        .flush       (flush),
        .free_cnt    (free_cnt),
        .empty       (empty),
        .busy_map    (busy_map),
        .err_dblfree (err_dblfree)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req = 1'b0; alloc_prio = 1'b0;
        free0_en  = 1'b0; free0_tag  = '0;
        free1_en  = 1'b0; free1_tag  = '0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        do_reset();

        chk("rst_gnt",   64'(alloc_gnt),   64'd0);
        chk("rst_tag",   64'(alloc_tag),   64'd0);
        chk("rst_cnt",   64'(free_cnt),    64'd64);
        chk("rst_empty", 64'(empty),       64'd0);
        chk("rst_busy",  busy_map,         64'd0);
        chk("rst_err",   64'(err_dblfree), 64'd0);

        // Three priority grants: tags 0,1,2
        alloc_req = 1'b1; alloc_prio = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("seq_gnt", 64'(alloc_gnt), 64'd1);
            chk("seq_tag", 64'(alloc_tag), 64'(i));
            chk("seq_cnt", 64'(free_cnt),  64'(63 - i));
        end
        alloc_req = 1'b0;
        step();
        chk("idle_gnt",  64'(alloc_gnt), 64'd0);
        chk("idle_hold", 64'(alloc_tag), 64'd2);

        // Tags 3..5, then free tag 3 while requesting
        alloc_req = 1'b1;
        for (int i = 3; i < 6; i++) begin
            step();
            chk("a35_tag", 64'(alloc_tag), 64'(i));
        end
        chk("a35_cnt", 64'(free_cnt), 64'd58);
        free0_en = 1'b1; free0_tag = 6'd3;
        step();
        chk("ovl_gnt", 64'(alloc_gnt), 64'd1);
        chk("ovl_tag", 64'(alloc_tag), 64'd6);
        chk("ovl_cnt", 64'(free_cnt),  64'd58);
        chk("ovl_err", 64'(err_dblfree), 64'd0);
        free0_en = 1'b0;
        step();
        chk("reuse_tag", 64'(alloc_tag), 64'd3);
        chk("reuse_cnt", 64'(free_cnt),  64'd57);
        chk("reuse_map", busy_map,       64'h7F);
        alloc_req = 1'b0;

        // Double free of tag 9 (already free)
        free0_en = 1'b1; free0_tag = 6'd9;
        step();
        chk("dbl9_err", 64'(err_dblfree), 64'd1);
        chk("dbl9_cnt", 64'(free_cnt),    64'd57);
        chk("dbl9_map", busy_map,         64'h7F);
        free0_en = 1'b0;
        step();
        chk("dbl9_pulse", 64'(err_dblfree), 64'd0);

        // Both ports release tag 0 in one cycle
        free0_en = 1'b1; free0_tag = 6'd0;
        free1_en = 1'b1; free1_tag = 6'd0;
        step();
        chk("dup_cnt", 64'(free_cnt),    64'd58);
        chk("dup_err", 64'(err_dblfree), 64'd1);
        chk("dup_map", busy_map,         64'h7E);
        idle();
        step();
        chk("dup_pulse", 64'(err_dblfree), 64'd0);

        // Two distinct legal releases in one cycle
        free0_en = 1'b1; free0_tag = 6'd1;
        free1_en = 1'b1; free1_tag = 6'd5;
        step();
        chk("two_cnt", 64'(free_cnt),    64'd60);
        chk("two_map", busy_map,         64'h5C);
        chk("two_err", 64'(err_dblfree), 64'd0);
        idle();

        // Flush with 10 tags held, request and release in the same cycle
        do_reset();
        alloc_req = 1'b1; alloc_prio = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("hold10_cnt", 64'(free_cnt), 64'd54);
        chk("hold10_map", busy_map,      64'h3FF);
        flush = 1'b1; free0_en = 1'b1; free0_tag = 6'd2;
        step();
        chk("fl_gnt", 64'(alloc_gnt),   64'd0);
        chk("fl_cnt", 64'(free_cnt),    64'd64);
        chk("fl_map", busy_map,         64'd0);
        chk("fl_err", 64'(err_dblfree), 64'd0);
        flush = 1'b0; free0_en = 1'b0;
        step();
        chk("pfl_gnt", 64'(alloc_gnt), 64'd1);
        chk("pfl_tag", 64'(alloc_tag), 64'd0);
        chk("pfl_cnt", 64'(free_cnt),  64'd63);

        // Release the tag being picked this cycle: grant goes ahead, error flagged
        free0_en = 1'b1; free0_tag = 6'd1;
        step();
        chk("pk_tag", 64'(alloc_tag),   64'd1);
        chk("pk_err", 64'(err_dblfree), 64'd1);
        chk("pk_cnt", 64'(free_cnt),    64'd62);
        idle();

        // Reserve watermark: non-priority stops at 4 free
        do_reset();
        alloc_req = 1'b1; alloc_prio = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            chk("np_gnt", 64'(alloc_gnt), 64'd1);
            chk("np_tag", 64'(alloc_tag), 64'(i));
        end
        step();
        chk("resv_gnt",  64'(alloc_gnt), 64'd0);
        chk("resv_cnt",  64'(free_cnt),  64'd4);
        chk("resv_hold", 64'(alloc_tag), 64'd59);
        alloc_prio = 1'b1;
        for (int i = 60; i < 64; i++) begin
            step();
            chk("pr_gnt", 64'(alloc_gnt), 64'd1);
            chk("pr_tag", 64'(alloc_tag), 64'(i));
        end
        chk("full_empty", 64'(empty),    64'd1);
        chk("full_cnt",   64'(free_cnt), 64'd0);
        chk("full_map",   busy_map,      64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk("full_gnt",   64'(alloc_gnt), 64'd0);
        step();
        chk("full_gnt2",  64'(alloc_gnt), 64'd0);

        // Reset mid-operation wins over flush
        rst = 1'b1; flush = 1'b1;
        step();
        chk("mrst_cnt", 64'(free_cnt),  64'd64);
        chk("mrst_tag", 64'(alloc_tag), 64'd0);
        chk("mrst_map", busy_map,       64'd0);
        rst = 1'b0;
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
